// File: rtl/stopwatch_lap.sv
// stopwatch_lap: tenth-second stopwatch with lap (split) capture, a BCD minutes
// range and a sticky overflow flag.
//
// Parameters
//   DIV        clk cycles per tenth-second tick (2..65535)
//   MIN_LIMIT  minutes wrap modulus (1..100)
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous reset, active low
//   strtstop   start/stop pushbutton, active low, asynchronous
//   lap        lap pushbutton, active high, asynchronous
//   clr        clear, active high, honoured only when not running
//   running    1 while counting
//   lap_active 1 while the display shows the frozen snapshot
//   overflow   sticky: set when the minutes wrap
//   tenths_n   active-low one-hot tenths digit of the displayed time
//   sec_ones, sec_tens, min_ones, min_tens  BCD digits of the displayed time
module stopwatch_lap #(
  parameter int unsigned DIV       = 16,
  parameter int unsigned MIN_LIMIT = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strtstop,
  input  logic       lap,
  input  logic       clr,
  output logic       running,
  output logic       lap_active,
  output logic       overflow,
  output logic [9:0] tenths_n,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens
);

  localparam int unsigned PW         = $clog2(DIV);
  localparam logic [PW-1:0] PrescMax = PW'(DIV - 1);
  localparam logic [3:0] MaxMinTens  = 4'((MIN_LIMIT - 1) / 10);
  localparam logic [3:0] MaxMinOnes  = 4'((MIN_LIMIT - 1) % 10);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronisers plus rising-edge detect.
  // strtstop is inverted first so a press is a 0->1 edge like lap.
  // ---------------------------------------------------------------------------
  logic [1:0] r_ss_sync, r_lap_sync, r_clr_sync;
  logic       r_ss_prev, r_lap_prev;
  logic       w_start_ev, w_lap_ev, w_clr_lvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ss_sync  <= 2'b00;
      r_lap_sync <= 2'b00;
      r_clr_sync <= 2'b00;
      r_ss_prev  <= 1'b0;
      r_lap_prev <= 1'b0;
    end else begin
      r_ss_sync  <= {r_ss_sync[0], ~strtstop};
      r_lap_sync <= {r_lap_sync[0], lap};
      r_clr_sync <= {r_clr_sync[0], clr};
      r_ss_prev  <= r_ss_sync[1];
      r_lap_prev <= r_lap_sync[1];
    end
  end

  assign w_start_ev = r_ss_sync[1] & ~r_ss_prev;
  assign w_lap_ev   = r_lap_sync[1] & ~r_lap_prev;
  assign w_clr_lvl  = r_clr_sync[1];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_e r_state, w_state_nxt;
  logic   w_clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_clr_lvl && w_start_ev) w_state_nxt = StRun;
      end
      StRun: begin
        if (w_start_ev) w_state_nxt = StStop;
      end
      StStop: begin
        if (w_clr_lvl)       w_state_nxt = StIdle;
        else if (w_start_ev) w_state_nxt = StRun;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    running = (r_state == StRun);
  end

  // Clear is only honoured outside RUN; it returns everything to the idle values.
  assign w_clear = w_clr_lvl && (r_state != StRun);

  // ---------------------------------------------------------------------------
  // Tick prescaler: runs in RUN, holds in STOP so a resume finishes the
  // partial tenth, zeroed in IDLE.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_state == StRun) && (r_presc == PrescMax);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_clear || (r_state == StIdle)) begin
      r_presc <= '0;
    end else if (r_state == StRun) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Live BCD counter: tenths -> seconds -> minutes (two BCD digits)
  // ---------------------------------------------------------------------------
  logic [3:0] r_t, r_so, r_st, r_mo, r_mt;
  logic [3:0] w_t_d, w_so_d, w_st_d, w_mo_d, w_mt_d;
  logic       w_wrap;
  logic       r_ovf;

  always_comb begin
    w_t_d  = r_t;
    w_so_d = r_so;
    w_st_d = r_st;
    w_mo_d = r_mo;
    w_mt_d = r_mt;
    w_wrap = 1'b0;
    if (w_clear) begin
      w_t_d  = 4'd0;
      w_so_d = 4'd0;
      w_st_d = 4'd0;
      w_mo_d = 4'd0;
      w_mt_d = 4'd0;
    end else if (w_tick) begin
      if (r_t != 4'd9) begin
        w_t_d = r_t + 4'd1;
      end else begin
        w_t_d = 4'd0;
        if (r_so != 4'd9) begin
          w_so_d = r_so + 4'd1;
        end else begin
          w_so_d = 4'd0;
          if (r_st != 4'd5) begin
            w_st_d = r_st + 4'd1;
          end else begin
            w_st_d = 4'd0;
            if ((r_mt == MaxMinTens) && (r_mo == MaxMinOnes)) begin
              w_mo_d = 4'd0;
              w_mt_d = 4'd0;
              w_wrap = 1'b1;
            end else if (r_mo == 4'd9) begin
              w_mo_d = 4'd0;
              w_mt_d = r_mt + 4'd1;
            end else begin
              w_mo_d = r_mo + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_t   <= 4'd0;
      r_so  <= 4'd0;
      r_st  <= 4'd0;
      r_mo  <= 4'd0;
      r_mt  <= 4'd0;
      r_ovf <= 1'b0;
    end else begin
      r_t  <= w_t_d;
      r_so <= w_so_d;
      r_st <= w_st_d;
      r_mo <= w_mo_d;
      r_mt <= w_mt_d;
      if (w_clear)     r_ovf <= 1'b0;
      else if (w_wrap) r_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Lap snapshot. Evaluated against the pre-transition state and captures the
  // pre-tick live value, so a coincident start/stop or tick never leaks in.
  // ---------------------------------------------------------------------------
  logic [3:0] r_snap_t, r_snap_so, r_snap_st, r_snap_mo, r_snap_mt;
  logic       r_lap_act;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap_t  <= 4'd0;
      r_snap_so <= 4'd0;
      r_snap_st <= 4'd0;
      r_snap_mo <= 4'd0;
      r_snap_mt <= 4'd0;
      r_lap_act <= 1'b0;
    end else if (w_clear) begin
      r_snap_t  <= 4'd0;
      r_snap_so <= 4'd0;
      r_snap_st <= 4'd0;
      r_snap_mo <= 4'd0;
      r_snap_mt <= 4'd0;
      r_lap_act <= 1'b0;
    end else if (w_lap_ev) begin
      if ((r_state == StRun) && !r_lap_act) begin
        r_snap_t  <= r_t;
        r_snap_so <= r_so;
        r_snap_st <= r_st;
        r_snap_mo <= r_mo;
        r_snap_mt <= r_mt;
        r_lap_act <= 1'b1;
      end else if (r_lap_act && (r_state != StIdle)) begin
        r_lap_act <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display mux
  // ---------------------------------------------------------------------------
  logic [3:0] w_disp_t;

  assign lap_active = r_lap_act;
  assign overflow   = r_ovf;
  assign w_disp_t   = r_lap_act ? r_snap_t  : r_t;
  assign sec_ones   = r_lap_act ? r_snap_so : r_so;
  assign sec_tens   = r_lap_act ? r_snap_st : r_st;
  assign min_ones   = r_lap_act ? r_snap_mo : r_mo;
  assign min_tens   = r_lap_act ? r_snap_mt : r_mt;

  always_comb begin
    tenths_n = '1;
    for (int k = 0; k < 10; k++) begin
      if (w_disp_t == 4'(k)) tenths_n[k] = 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap. u_dut (DIV=4, MIN_LIMIT=60) runs the
// vector table; u_ovf (DIV=2, MIN_LIMIT=2) runs the overflow sequence. Expected
// values are pushed to a queue as each stimulus is driven and popped when the
// DUT outputs are sampled on the falling clock edge.
module tb_stopwatch_lap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, strtstop, lap, clr;
  logic       running, lap_active, overflow;
  logic [9:0] tenths_n;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;

  logic       ov_ss, ov_lap, ov_clr;
  logic       ov_running, ov_lap_active, ov_overflow;
  logic [9:0] ov_tenths_n;
  logic [3:0] ov_sec_ones, ov_sec_tens, ov_min_ones, ov_min_tens;

  stopwatch_lap #(.DIV(4), .MIN_LIMIT(60)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .strtstop   (strtstop),
    .lap        (lap),
    .clr        (clr),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .tenths_n   (tenths_n),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens)
  );

  stopwatch_lap #(.DIV(2), .MIN_LIMIT(2)) u_ovf (
    .clk        (clk),
    .reset      (reset),
    .strtstop   (ov_ss),
    .lap        (ov_lap),
    .clr        (ov_clr),
    .running    (ov_running),
    .lap_active (ov_lap_active),
    .overflow   (ov_overflow),
    .tenths_n   (ov_tenths_n),
    .sec_ones   (ov_sec_ones),
    .sec_tens   (ov_sec_tens),
    .min_ones   (ov_min_ones),
    .min_tens   (ov_min_tens)
  );

  typedef enum int {ActNone, ActSs, ActLap, ActClr, ActBoth} act_e;

  // tm is {min_tens, min_ones, sec_tens, sec_ones, tenths} in BCD
  typedef struct {
    string       name;
    act_e        act;
    int unsigned wait_cyc;
    logic        run;
    logic        lapa;
    logic        ovf;
    logic [19:0] tm;
  } vec_t;

  typedef struct {
    string       name;
    logic        run;
    logic        lapa;
    logic        ovf;
    logic [19:0] tm;
  } exp_t;

  vec_t        vecs[$];
  exp_t        exp_q[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input string nm, input logic r, input logic la, input logic ov,
                          input logic [19:0] tm);
    exp_t e;
    e.name = nm;
    e.run  = r;
    e.lapa = la;
    e.ovf  = ov;
    e.tm   = tm;
    exp_q.push_back(e);
  endtask

  // Pop one expectation and compare it with u_dut (sel=0) or u_ovf (sel=1).
  task automatic pop_cmp(input bit sel);
    exp_t        e;
    logic        r, la, ov;
    logic [9:0]  tn, etn;
    logic [15:0] dg;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    if (sel) begin
      r  = ov_running;
      la = ov_lap_active;
      ov = ov_overflow;
      tn = ov_tenths_n;
      dg = {ov_min_tens, ov_min_ones, ov_sec_tens, ov_sec_ones};
    end else begin
      r  = running;
      la = lap_active;
      ov = overflow;
      tn = tenths_n;
      dg = {min_tens, min_ones, sec_tens, sec_ones};
    end
    etn = ~(10'd1 << e.tm[3:0]);
    check({e.name, "/running"},    32'(r),  32'(e.run));
    check({e.name, "/lap_active"}, 32'(la), 32'(e.lapa));
    check({e.name, "/overflow"},   32'(ov), 32'(e.ovf));
    check({e.name, "/tenths_n"},   32'(tn), 32'(etn));
    check({e.name, "/digits"},     32'(dg), 32'(e.tm[19:4]));
  endtask

  initial begin
    // Negedge index after reset release in the trailing comment of each row.
    vecs.push_back('{"idle_hold",      ActNone, 5,    1'b0, 1'b0, 1'b0, 20'h00000}); // 5
    vecs.push_back('{"lap_in_idle",    ActLap,  6,    1'b0, 1'b0, 1'b0, 20'h00000}); // 11
    vecs.push_back('{"start",          ActSs,   3,    1'b1, 1'b0, 1'b0, 20'h00000}); // 14
    vecs.push_back('{"count_40",       ActNone, 160,  1'b1, 1'b0, 1'b0, 20'h00040}); // 174
    vecs.push_back('{"stop",           ActSs,   3,    1'b0, 1'b0, 1'b0, 20'h00040}); // 177
    vecs.push_back('{"stop_hold",      ActNone, 50,   1'b0, 1'b0, 1'b0, 20'h00040}); // 227
    vecs.push_back('{"resume",         ActSs,   3,    1'b1, 1'b0, 1'b0, 20'h00040}); // 230
    vecs.push_back('{"resume_tick",    ActNone, 1,    1'b1, 1'b0, 1'b0, 20'h00041}); // 231
    vecs.push_back('{"clr_in_run",     ActClr,  8,    1'b1, 1'b0, 1'b0, 20'h00043}); // 239
    vecs.push_back('{"stop2",          ActSs,   3,    1'b0, 1'b0, 1'b0, 20'h00043}); // 242
    vecs.push_back('{"clr_in_stop",    ActClr,  3,    1'b0, 1'b0, 1'b0, 20'h00000}); // 245
    vecs.push_back('{"idle_after_clr", ActNone, 4,    1'b0, 1'b0, 1'b0, 20'h00000}); // 249
    vecs.push_back('{"start2",         ActSs,   3,    1'b1, 1'b0, 1'b0, 20'h00000}); // 252
    vecs.push_back('{"run_to_lap",     ActNone, 108,  1'b1, 1'b0, 1'b0, 20'h00027}); // 360
    vecs.push_back('{"lap_freeze",     ActLap,  3,    1'b1, 1'b1, 1'b0, 20'h00027}); // 363
    vecs.push_back('{"lap_hold",       ActNone, 40,   1'b1, 1'b1, 1'b0, 20'h00027}); // 403
    vecs.push_back('{"wait_to_51",     ActNone, 53,   1'b1, 1'b1, 1'b0, 20'h00027}); // 456
    vecs.push_back('{"lap_release",    ActLap,  3,    1'b1, 1'b0, 1'b0, 20'h00051}); // 459
    vecs.push_back('{"live_after_lap", ActNone, 1,    1'b1, 1'b0, 1'b0, 20'h00052}); // 460
    vecs.push_back('{"to_59_9",        ActNone, 2191, 1'b1, 1'b0, 1'b0, 20'h00599}); // 2651
    vecs.push_back('{"one_minute",     ActNone, 1,    1'b1, 1'b0, 1'b0, 20'h01000}); // 2652
    vecs.push_back('{"wait_coinc",     ActNone, 5,    1'b1, 1'b0, 1'b0, 20'h01001}); // 2657
    vecs.push_back('{"stop_lap_tick",  ActBoth, 3,    1'b0, 1'b1, 1'b0, 20'h01001}); // 2660
    vecs.push_back('{"coinc_held",     ActNone, 10,   1'b0, 1'b1, 1'b0, 20'h01001}); // 2670
    vecs.push_back('{"lap_off_stop",   ActLap,  3,    1'b0, 1'b0, 1'b0, 20'h01002}); // 2673
    vecs.push_back('{"clr_final",      ActClr,  3,    1'b0, 1'b0, 1'b0, 20'h00000}); // 2676

    reset    = 1'b0;
    strtstop = 1'b1;
    lap      = 1'b0;
    clr      = 1'b0;
    ov_ss    = 1'b1;
    ov_lap   = 1'b0;
    ov_clr   = 1'b0;

    push_exp("reset_main", 1'b0, 1'b0, 1'b0, 20'h00000);
    push_exp("reset_ovf",  1'b0, 1'b0, 1'b0, 20'h00000);
    cyc(3);
    pop_cmp(1'b0);
    pop_cmp(1'b1);
    reset = 1'b1;

    // Each press is held two cycles, then released for the rest of the wait.
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      push_exp(v.name, v.run, v.lapa, v.ovf, v.tm);
      case (v.act)
        ActSs:   strtstop = 1'b0;
        ActLap:  lap = 1'b1;
        ActClr:  clr = 1'b1;
        ActBoth: begin
          strtstop = 1'b0;
          lap      = 1'b1;
        end
        default: ;
      endcase
      if (v.act != ActNone) begin
        cyc(2);
        strtstop = 1'b1;
        lap      = 1'b0;
        clr      = 1'b0;
        cyc(v.wait_cyc - 2);
      end else begin
        cyc(v.wait_cyc);
      end
      pop_cmp(1'b0);
    end

    // Overflow: DIV=2, MIN_LIMIT=2, a tick every 2 cycles after start.
    push_exp("ov_start", 1'b1, 1'b0, 1'b0, 20'h00000);
    ov_ss = 1'b0;
    cyc(2);
    ov_ss = 1'b1;
    cyc(1);
    pop_cmp(1'b1);
    push_exp("ov_1_59_9", 1'b1, 1'b0, 1'b0, 20'h01599);
    cyc(2399);
    pop_cmp(1'b1);
    push_exp("ov_wrap", 1'b1, 1'b0, 1'b1, 20'h00000);
    cyc(1);
    pop_cmp(1'b1);
    push_exp("ov_continue", 1'b1, 1'b0, 1'b1, 20'h00001);
    cyc(2);
    pop_cmp(1'b1);
    push_exp("ov_sticky", 1'b1, 1'b0, 1'b1, 20'h01000);
    cyc(1198);
    pop_cmp(1'b1);
    push_exp("ov_stop", 1'b0, 1'b0, 1'b1, 20'h01001);
    ov_ss = 1'b0;
    cyc(2);
    ov_ss = 1'b1;
    cyc(1);
    pop_cmp(1'b1);
    push_exp("ov_clr", 1'b0, 1'b0, 1'b0, 20'h00000);
    ov_clr = 1'b1;
    cyc(2);
    ov_clr = 1'b0;
    cyc(1);
    pop_cmp(1'b1);

    // Asynchronous reset while running with a lap frozen.
    push_exp("rst_start", 1'b1, 1'b0, 1'b0, 20'h00000);
    strtstop = 1'b0;
    cyc(2);
    strtstop = 1'b1;
    cyc(1);
    pop_cmp(1'b0);
    push_exp("rst_run", 1'b1, 1'b0, 1'b0, 20'h00005);
    cyc(20);
    pop_cmp(1'b0);
    push_exp("rst_lap", 1'b1, 1'b1, 1'b0, 20'h00005);
    lap = 1'b1;
    cyc(2);
    lap = 1'b0;
    cyc(1);
    pop_cmp(1'b0);
    push_exp("rst_async", 1'b0, 1'b0, 1'b0, 20'h00000);
    #2 reset = 1'b0;
    #1 pop_cmp(1'b0);
    cyc(1);
    push_exp("rst_release", 1'b0, 1'b0, 1'b0, 20'h00000);
    reset = 1'b1;
    cyc(6);
    pop_cmp(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
